// File: rtl/float_pkg.sv
// float_pkg: shared float helpers and reduction FSM state encoding
package float_pkg;
  localparam int FP_W = 32;
  localparam int FP_EXP_W = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACC = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return &x[FP_W-2 -: FP_EXP_W] && |x[FP_W-FP_EXP_W-2:0];
  endfunction
  function automatic logic sign(input logic [FP_W-1:0] x);
    return x[FP_W-1];
  endfunction
  function automatic logic [FP_W-2:0] magnitude(input logic [FP_W-1:0] x);
    return x[FP_W-2:0];
  endfunction
endpackage

// File: rtl/float_lt_core.sv
// float_lt_core: combinational a < b float ordering (-0 < +0, NaN-agnostic); ports a, b in, lt out
module float_lt_core import float_pkg::*; #(
  parameter int DATA_W = FP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              lt
);
  assign lt = (sign(a) != sign(b)) ? sign(a) :
              sign(a) ? (magnitude(a) > magnitude(b)) : (magnitude(a) < magnitude(b));
endmodule

// File: rtl/float_minmax_reduce.sv
// float_minmax_reduce: streaming float min/max reduction (clk, rst, running, run, length, mode, in0 -> out0 value, out1 index, done, nan_seen); FLOAT_MINMAX_INDEX_EN enables the index register
module float_minmax_reduce import float_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              running,
  input  logic              run,
  input  logic [CNT_W-1:0]  length,
  input  logic              mode,
  input  logic [DATA_W-1:0] in0,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              done,
  output logic              nan_seen
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic have, nan, better;
  logic [DATA_W-1:0] a, b;
  assign nan = &in0[DATA_W-2 -: EXP_W] && |in0[DATA_W-EXP_W-2:0];
  assign a = mode ? out0 : in0;
  assign b = mode ? in0 : out0;
  float_lt_core #(.DATA_W(DATA_W)) u_lt (.a(a), .b(b), .lt(better));
`ifdef FLOAT_MINMAX_INDEX_EN
  logic [CNT_W-1:0] idx;
  assign out1 = DATA_W'(idx);
`else
  assign out1 = '0;
`endif
  always_ff @(posedge clk) begin
    if (rst || run) begin
      state    <= rst ? ST_IDLE : ST_ACC;
      cnt      <= '0;
      have     <= 1'b0;
      done     <= 1'b0;
      nan_seen <= 1'b0;
      out0     <= '0;
`ifdef FLOAT_MINMAX_INDEX_EN
      idx      <= '0;
`endif
    end else if (state == ST_ACC) begin
      if (cnt == length) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end else if (running) begin
        cnt <= cnt + 1'b1;
        if (nan) nan_seen <= 1'b1;
        else if (!have || better) begin
          out0 <= in0;
          have <= 1'b1;
`ifdef FLOAT_MINMAX_INDEX_EN
          idx  <= cnt;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_float_minmax_reduce.sv
// tb_float_minmax_reduce: directed self-checking bench with a sample-list reference model
module tb_float_minmax_reduce;
  logic clk = 1'b0;
  logic rst, running, run, mode, done, nan_seen;
  logic [15:0] length;
  logic [31:0] in0, out0, out1;
  int checks = 0;
  int errors = 0;
`ifdef FLOAT_MINMAX_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif
  always #5 clk = ~clk;
  float_minmax_reduce dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .length(length), .mode(mode),
    .in0(in0), .out0(out0), .out1(out1), .done(done), .nan_seen(nan_seen)
  );
  typedef enum {M_IDLE, M_ACC, M_DONE} phase_t;
  phase_t ph = M_IDLE;
  logic [31:0] q[$];
  bit chk_en = 1'b0;
  bit e_done = 1'b0;
  bit e_nan = 1'b0;
  logic [31:0] e_out0 = '0;
  logic [31:0] e_out1 = '0;
  function automatic bit fnan(logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic logic [31:0] key(logic [31:0] x);
    return x[31] ? ~x : (x | 32'h8000_0000);
  endfunction
  task automatic recompute();
    bit found = 1'b0;
    int bi = 0;
    logic [31:0] best = '0;
    e_nan = 1'b0;
    foreach (q[i]) begin
      if (fnan(q[i])) e_nan = 1'b1;
      else if (!found || (mode ? key(q[i]) > key(best) : key(q[i]) < key(best))) begin
        found = 1'b1;
        best = q[i];
        bi = i;
      end
    end
    e_out0 = best;
    e_out1 = (found && IDX_EN) ? 32'(bi) : 32'd0;
  endtask
  always @(posedge clk) begin
    if (rst) begin
      chk_en = 1'b1;
      ph = M_IDLE;
      q.delete();
      e_done = 1'b0;
    end else if (run) begin
      ph = M_ACC;
      q.delete();
      e_done = 1'b0;
    end else if (ph == M_ACC) begin
      if (q.size() == int'(length)) begin
        ph = M_DONE;
        e_done = 1'b1;
      end else if (running) q.push_back(in0);
    end
    recompute();
  end
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("model_out0", out0, e_out0);
    check("model_out1", out1, e_out1);
    check("model_done", 32'(done), 32'(e_done));
    check("model_nan", 32'(nan_seen), 32'(e_nan));
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic start(bit m, int len);
    mode = m;
    length = 16'(len);
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask
  task automatic feed(logic [31:0] x);
    in0 = x;
    running = 1'b1;
    tick();
    running = 1'b0;
    in0 = 32'hDEAD_BEEF;
  endtask
  task automatic idle(int k);
    running = 1'b0;
    repeat (k) tick();
  endtask
  initial begin
    rst = 1'b1; run = 1'b0; running = 1'b0; mode = 1'b0; length = '0; in0 = '0;
    repeat (2) tick();
    check("reset_out0", out0, 32'h0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    start(0, 4);
    feed(32'h4040_0000); feed(32'hBFC0_0000); feed(32'h4000_0000); feed(32'hBFC0_0000);
    check("t1_done_early", 32'(done), 32'd0);
    idle(1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_out0", out0, 32'hBFC0_0000);
    check("t1_out1", out1, IDX_EN ? 32'd1 : 32'd0);
    feed(32'hC200_0000);
    check("t1_hold_done", out0, 32'hBFC0_0000);
    start(1, 3);
    feed(32'h8000_0000); feed(32'h0000_0000); feed(32'hC000_0000);
    idle(1);
    check("t2_done", 32'(done), 32'd1);
    check("t2_out0", out0, 32'h0000_0000);
    check("t2_out1", out1, IDX_EN ? 32'd1 : 32'd0);
    start(0, 3);
    feed(32'h7FC0_0001); feed(32'h40A0_0000); feed(32'h7F80_0000);
    idle(1);
    check("t3_out0", out0, 32'h40A0_0000);
    check("t3_out1", out1, IDX_EN ? 32'd1 : 32'd0);
    check("t3_nan", 32'(nan_seen), 32'd1);
    start(0, 3);
    feed(32'h4040_0000);
    idle(2);
    feed(32'hBF80_0000);
    check("t4_done_gap", 32'(done), 32'd0);
    feed(32'h3F80_0000);
    check("t4_done_early", 32'(done), 32'd0);
    idle(1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_out0", out0, 32'hBF80_0000);
    start(1, 3);
    feed(32'h4100_0000); feed(32'h4110_0000);
    start(1, 2);
    check("t5_cleared", out0, 32'h0);
    feed(32'h3F80_0000); feed(32'h4000_0000);
    check("t5_done_early", 32'(done), 32'd0);
    idle(1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_out0", out0, 32'h4000_0000);
    start(0, 0);
    idle(1);
    check("len0_done", 32'(done), 32'd1);
    start(0, 2);
    feed(32'hFF80_0001); feed(32'h7FFF_FFFF);
    idle(1);
    check("allnan_done", 32'(done), 32'd1);
    check("allnan_out0", out0, 32'h0);
    check("allnan_nan", 32'(nan_seen), 32'd1);
    start(0, 3);
    feed(32'h4040_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out0", out0, 32'h0);
    feed(32'h3F80_0000); feed(32'h4000_0000); feed(32'h4040_0000);
    idle(2);
    check("t6_idle_out0", out0, 32'h0);
    check("t6_idle_done", 32'(done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
